// File: rtl/interp_sequencer_if.sv
// interp_sequencer_if: command, strobe and response signals of interp_sequencer.
// The master modport is the sequencer and the slave modport is its environment
// (solver control unit plus interpolation module).
// lat_last and CNT_WIDTH exist only when INTERP_LAT_CNT_EN is defined.
interface interp_sequencer_if #(
    parameter int unsigned WORD_SIZE     = 16,
    parameter int unsigned ADDRESS_WIDTH = 16
`ifdef INTERP_LAT_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH     = 16
`endif
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               cmd_type;
    logic [WORD_SIZE-1:0]     cmd_tk;
    logic [ADDRESS_WIDTH-1:0] cmd_uk;
    logic                     init_sg;
    logic                     update_sg;
    logic                     start_sg;
    logic                     alert_sg;
    logic [WORD_SIZE-1:0]     tk_port;
    logic [ADDRESS_WIDTH-1:0] uk_port;
    logic                     done_sg;
    logic                     overflow;
    logic                     resp_valid;
    logic                     resp_overflow;
    logic                     resp_timeout;
    logic [1:0]               err_sticky;
    logic                     clr_err;
`ifdef INTERP_LAT_CNT_EN
    logic [CNT_WIDTH-1:0]     lat_last;
`endif

    modport master (
        input  cmd_valid, cmd_type, cmd_tk, cmd_uk, done_sg, overflow, clr_err,
        output cmd_ready, init_sg, update_sg, start_sg, alert_sg, tk_port, uk_port,
`ifdef INTERP_LAT_CNT_EN
        output lat_last,
`endif
        output resp_valid, resp_overflow, resp_timeout, err_sticky
    );

    modport slave (
        output cmd_valid, cmd_type, cmd_tk, cmd_uk, done_sg, overflow, clr_err,
        input  cmd_ready, init_sg, update_sg, start_sg, alert_sg, tk_port, uk_port,
`ifdef INTERP_LAT_CNT_EN
        input  lat_last,
`endif
        input  resp_valid, resp_overflow, resp_timeout, err_sticky
    );
endinterface

// File: rtl/interp_sequencer.sv
// interp_sequencer: accepts one command at a time, fires the matching strobe to the
// interpolation module, waits for done_sg (START only) or a timeout, then returns a
// one-cycle response and accumulates sticky error flags.
// Optional: define INTERP_LAT_CNT_EN to add lat_last (WAIT_DONE length of last START).
module interp_sequencer #(
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned ADDRESS_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic                clk,
    input logic                rst,
    interp_sequencer_if.master bus
);
    localparam logic [1:0] CmdInit   = 2'd0;
    localparam logic [1:0] CmdUpdate = 2'd1;
    localparam logic [1:0] CmdStart  = 2'd2;
    localparam logic [1:0] CmdAlert  = 2'd3;

    localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
    // Only meaningful when TimeoutEn; wraps harmlessly otherwise.
    localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPulse, StWaitDone, StComplete} state_e;

    state_e                   state;
    logic [1:0]               type_q;
    logic [CNT_WIDTH-1:0]     cnt_q;
    logic [WORD_SIZE-1:0]     tk_q;
    logic [ADDRESS_WIDTH-1:0] uk_q;

    logic [CNT_WIDTH-1:0]     cnt_inc;
    logic [1:0]               err_base;
    logic                     timeout_hit;

    assign bus.tk_port = tk_q;
    assign bus.uk_port = uk_q;

`ifdef INTERP_LAT_CNT_EN
    logic [CNT_WIDTH-1:0] lat_q;
    assign bus.lat_last = lat_q;
`endif

    // Saturating counter increment, sticky base after clear, timeout detect
    always_comb begin
        cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        err_base    = bus.clr_err ? 2'b00 : bus.err_sticky;
        timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);
    end

    // Sequencer FSM with registered strobes, handshake and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= StIdle;
            type_q            <= CmdInit;
            cnt_q             <= '0;
            tk_q              <= '0;
            uk_q              <= '0;
            bus.cmd_ready     <= 1'b1;
            bus.init_sg       <= 1'b0;
            bus.update_sg     <= 1'b0;
            bus.start_sg      <= 1'b0;
            bus.alert_sg      <= 1'b0;
            bus.resp_valid    <= 1'b0;
            bus.resp_overflow <= 1'b0;
            bus.resp_timeout  <= 1'b0;
            bus.err_sticky    <= 2'b00;
`ifdef INTERP_LAT_CNT_EN
            lat_q             <= '0;
`endif
        end else begin
            // Strobes and response are single-cycle pulses by default
            bus.init_sg       <= 1'b0;
            bus.update_sg     <= 1'b0;
            bus.start_sg      <= 1'b0;
            bus.alert_sg      <= 1'b0;
            bus.resp_valid    <= 1'b0;
            bus.resp_overflow <= 1'b0;
            bus.resp_timeout  <= 1'b0;
            bus.err_sticky    <= err_base;

            unique case (state)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        type_q        <= bus.cmd_type;
                        tk_q          <= bus.cmd_tk;
                        uk_q          <= bus.cmd_uk;
                        bus.cmd_ready <= 1'b0;
                        state         <= StPulse;
                        unique case (bus.cmd_type)
                            CmdInit:   bus.init_sg   <= 1'b1;
                            CmdUpdate: bus.update_sg <= 1'b1;
                            CmdStart:  bus.start_sg  <= 1'b1;
                            CmdAlert:  bus.alert_sg  <= 1'b1;
                            default:   ;
                        endcase
                    end
                end
                StPulse: begin
                    if (type_q == CmdStart) begin
                        cnt_q <= '0;
                        state <= StWaitDone;
                    end else begin
                        bus.resp_valid <= 1'b1;
                        state          <= StComplete;
                    end
                end
                StWaitDone: begin
                    // done takes priority over a coincident timeout
                    if (bus.done_sg || timeout_hit) begin
                        bus.resp_valid    <= 1'b1;
                        bus.resp_overflow <= bus.done_sg & bus.overflow;
                        bus.resp_timeout  <= ~bus.done_sg;
                        bus.err_sticky    <= err_base | {~bus.done_sg, bus.done_sg & bus.overflow};
`ifdef INTERP_LAT_CNT_EN
                        lat_q             <= cnt_inc;
`endif
                        state             <= StComplete;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StComplete: begin
                    bus.cmd_ready <= 1'b1;
                    state         <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_interp_sequencer.sv
// tb_interp_sequencer: directed stimulus with a response scoreboard for interp_sequencer.
// Responses are checked for cycle, overflow and timeout by an independent monitor.
module tb_interp_sequencer;
    localparam int unsigned TimeoutCycles = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic ov;
        logic to;
        int   cyc;
    } exp_t;
    exp_t exp_q[$];

`ifdef INTERP_LAT_CNT_EN
    interp_sequencer_if #(.WORD_SIZE(16), .ADDRESS_WIDTH(16), .CNT_WIDTH(16)) bus ();
`else
    interp_sequencer_if #(.WORD_SIZE(16), .ADDRESS_WIDTH(16)) bus ();
`endif

    interp_sequencer #(
        .WORD_SIZE      (16),
        .ADDRESS_WIDTH  (16),
        .CNT_WIDTH      (16),
        .TIMEOUT_CYCLES (TimeoutCycles)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every response pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)",
                             cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_overflow", bus.resp_overflow, e.ov);
                    chk("resp_timeout", bus.resp_timeout, e.to);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000 ns");
        $fatal(1);
    end

    // Issue one command; returns the cycle number in which the strobe is visible
    task automatic issue(input logic [1:0] t, input logic [15:0] tk, input logic [15:0] uk,
                         input bit push, input logic ov, input logic to, input int delay,
                         output int pulse);
        int n = 0;
        logic [3:0] one = 4'b1000;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = t;
        bus.cmd_tk    = tk;
        bus.cmd_uk    = uk;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", bus.cmd_ready, 1);
        pulse = cyc + 1;
        if (push) exp_q.push_back('{ov, to, pulse + delay});
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_tk    = 16'hdead;
        bus.cmd_uk    = 16'hbeef;
        chk("strobe", {bus.init_sg, bus.update_sg, bus.start_sg, bus.alert_sg}, one >> t);
        chk("tk_port", bus.tk_port, tk);
        chk("uk_port", bus.uk_port, uk);
        chk("busy_ready", bus.cmd_ready, 0);
    endtask

    // Drive done_sg during WAIT_DONE cycle k (k=1 is the first)
    task automatic done_at(input int k, input logic ov, input logic clr);
        repeat (k) @(negedge clk);
        bus.done_sg  = 1'b1;
        bus.overflow = ov;
        bus.clr_err  = clr;
        @(negedge clk);
        bus.done_sg  = 1'b0;
        bus.overflow = 1'b0;
        bus.clr_err  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_return", bus.cmd_ready, 1);
    endtask

    task automatic clear_err();
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        chk("err_cleared", bus.err_sticky, 2'b00);
    endtask

    initial begin
        int p;
        int p2;
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 2'b00;
        bus.cmd_tk    = '0;
        bus.cmd_uk    = '0;
        bus.done_sg   = 1'b0;
        bus.overflow  = 1'b0;
        bus.clr_err   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_strobes", {bus.init_sg, bus.update_sg, bus.start_sg, bus.alert_sg}, 0);
        chk("rst_resp", {bus.resp_valid, bus.resp_overflow, bus.resp_timeout}, 0);
        chk("rst_err", bus.err_sticky, 0);
        chk("rst_ports", {bus.tk_port, bus.uk_port}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.cmd_ready, 1);

        // INIT: strobe then response next cycle, ports hold afterwards
        issue(2'b00, 16'h0010, 16'h0100, 1'b1, 1'b0, 1'b0, 1, p);
        @(negedge clk);
        chk("strobe_one_cycle", {bus.init_sg, bus.update_sg, bus.start_sg, bus.alert_sg}, 0);
        chk("tk_hold", bus.tk_port, 16'h0010);
        chk("uk_hold", bus.uk_port, 16'h0100);

        // UPDATE then ALERT back-to-back
        issue(2'b01, 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b0, 1, p);
        issue(2'b11, 16'hffff, 16'h0001, 1'b1, 1'b0, 1'b0, 1, p2);
        chk("b2b_spacing", p2 - p, 3);
        wait_idle();
        chk("err_after_cmds", bus.err_sticky, 2'b00);

        // START, done after 5 wait cycles, no overflow
        issue(2'b10, 16'h0abc, 16'h0200, 1'b1, 1'b0, 1'b0, 6, p);
        done_at(5, 1'b0, 1'b0);
        wait_idle();
        chk("err_no_ovf", bus.err_sticky, 2'b00);
`ifdef INTERP_LAT_CNT_EN
        chk("lat_last_5", bus.lat_last, 5);
`endif

        // START with overflow
        issue(2'b10, 16'h0001, 16'h0300, 1'b1, 1'b1, 1'b0, 3, p);
        done_at(2, 1'b1, 1'b0);
        wait_idle();
        chk("err_ovf", bus.err_sticky, 2'b01);
        clear_err();

        // START with no done: timeout
        issue(2'b10, 16'h0002, 16'h0400, 1'b1, 1'b0, 1'b1, TimeoutCycles + 1, p);
        wait_idle();
        chk("err_timeout", bus.err_sticky, 2'b10);
`ifdef INTERP_LAT_CNT_EN
        chk("lat_last_to", bus.lat_last, TimeoutCycles);
`endif

        // Overflow completion with clr_err in the same cycle: set wins, timeout bit cleared
        issue(2'b10, 16'h0003, 16'h0500, 1'b1, 1'b1, 1'b0, 2, p);
        done_at(1, 1'b1, 1'b1);
        wait_idle();
        chk("err_set_wins", bus.err_sticky, 2'b01);
        clear_err();

        // done_sg on the timeout cycle: done wins
        issue(2'b10, 16'h0004, 16'h0600, 1'b1, 1'b0, 1'b0, TimeoutCycles + 1, p);
        done_at(TimeoutCycles, 1'b0, 1'b0);
        wait_idle();
        chk("err_done_wins", bus.err_sticky, 2'b00);

        // done_sg in IDLE is ignored
        @(negedge clk);
        bus.done_sg  = 1'b1;
        bus.overflow = 1'b1;
        @(negedge clk);
        bus.done_sg  = 1'b0;
        bus.overflow = 1'b0;
        @(negedge clk);
        chk("idle_done_no_resp", bus.resp_valid, 0);
        chk("idle_done_no_err", bus.err_sticky, 2'b00);
        chk("idle_done_ready", bus.cmd_ready, 1);

        // Set a sticky flag, then reset mid WAIT_DONE
        issue(2'b10, 16'h0005, 16'h0700, 1'b1, 1'b1, 1'b0, 2, p);
        done_at(1, 1'b1, 1'b0);
        wait_idle();
        chk("err_before_rst", bus.err_sticky, 2'b01);
        issue(2'b10, 16'h7777, 16'h8888, 1'b0, 1'b0, 1'b0, 0, p);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_ready", bus.cmd_ready, 1);
        chk("async_err", bus.err_sticky, 2'b00);
        chk("async_ports", {bus.tk_port, bus.uk_port}, 0);
        chk("async_strobes", {bus.init_sg, bus.update_sg, bus.start_sg, bus.alert_sg}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (TimeoutCycles + 4) @(negedge clk);
        chk("post_rst_ready", bus.cmd_ready, 1);
        chk("post_rst_no_resp", bus.resp_valid, 0);

        // Normal operation resumes
        issue(2'b00, 16'h0042, 16'h0043, 1'b1, 1'b0, 1'b0, 1, p);
        wait_idle();
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
